// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one spi_con master between NUM_REQ requesters.
// Issues one-cycle triggers, routes responses back, enforces a CS idle gap and a WAIT watchdog.
module spi_txn_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned GAP_CYCLES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic [NUM_REQ-1:0]            req_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
   input  logic [NUM_REQ-1:0]            req_lock_in,
   output logic [NUM_REQ-1:0]            grant_out,
   output logic [DATA_WIDTH-1:0]         rsp_data_out,
   output logic [NUM_REQ-1:0]            rsp_valid_out,
   output logic                          rsp_timeout_out,
   output logic                          busy_out,
   output logic [DATA_WIDTH-1:0]         spi_data_out,
   output logic                          spi_trigger_out,
   input  logic [DATA_WIDTH-1:0]         spi_data_in,
   input  logic                          spi_valid_in
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StWait, StGap} state_e;

   state_e                 state_q, state_d;
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [PW-1:0]          owner_q, owner_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic [DATA_WIDTH-1:0]  spi_data_q, spi_data_d;
   logic                   trig_q, trig_d;
   logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic                   rsp_to_q, rsp_to_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [GW-1:0]          gap_q, gap_d;
   logic                   pick_found;
   logic [PW-1:0]          pick_idx;

   function automatic logic [PW-1:0] wrap_add(logic [PW-1:0] base, int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return PW'(sum);
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(logic [PW-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] slice_of(logic [NUM_REQ*DATA_WIDTH-1:0] v,
                                                      logic [PW-1:0] idx);
      return v[32'(idx)*DATA_WIDTH +: DATA_WIDTH];
   endfunction

   // First asserted request scanning upward from the round-robin pointer.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         if (!pick_found && req_in[wrap_add(ptr_q, off)]) begin
            pick_found = 1'b1;
            pick_idx   = wrap_add(ptr_q, off);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      grant_d     = grant_q;
      spi_data_d  = spi_data_q;
      trig_d      = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = '0;
      rsp_to_d    = 1'b0;
      timer_d     = timer_q;
      gap_d       = gap_q;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               owner_d    = pick_idx;
               grant_d    = onehot(pick_idx);
               spi_data_d = slice_of(req_data_in, pick_idx);
               trig_d     = 1'b1;
               timer_d    = '0;
               state_d    = StWait;
            end
         end
         StWait: begin
            // A real response beats a coincident timeout.
            if (spi_valid_in) begin
               rsp_data_d  = spi_data_in;
               rsp_valid_d = grant_q;
               gap_d       = '0;
               state_d     = StGap;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               rsp_data_d  = '0;
               rsp_valid_d = grant_q;
               rsp_to_d    = 1'b1;
               gap_d       = '0;
               state_d     = StGap;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         StGap: begin
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
               if (req_lock_in[owner_q] && req_in[owner_q]) begin
                  spi_data_d = slice_of(req_data_in, owner_q);
                  trig_d     = 1'b1;
                  timer_d    = '0;
                  state_d    = StWait;
               end else begin
                  grant_d = '0;
                  ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
                  state_d = StIdle;
               end
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         owner_q     <= '0;
         grant_q     <= '0;
         spi_data_q  <= '0;
         trig_q      <= 1'b0;
         rsp_data_q  <= '0;
         rsp_valid_q <= '0;
         rsp_to_q    <= 1'b0;
         timer_q     <= '0;
         gap_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         grant_q     <= grant_d;
         spi_data_q  <= spi_data_d;
         trig_q      <= trig_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_to_q    <= rsp_to_d;
         timer_q     <= timer_d;
         gap_q       <= gap_d;
      end
   end

   assign grant_out       = grant_q;
   assign rsp_data_out    = rsp_data_q;
   assign rsp_valid_out   = rsp_valid_q;
   assign rsp_timeout_out = rsp_to_q;
   assign busy_out        = (state_q != StIdle);
   assign spi_data_out    = spi_data_q;
   assign spi_trigger_out = trig_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter: instance a uses the default watchdog, instance b a
// 64-cycle watchdog. The spi_con model answers with the sent word XOR 0x99.
module tb_spi_txn_arbiter;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int GAP = 4;

   typedef struct {
      int           inst;
      logic [N-1:0] grant;
      logic [DW-1:0] data;
   } trig_t;

   typedef struct {
      int            inst;
      logic [N-1:0]  valid;
      logic [DW-1:0] data;
      logic          to;
   } rsp_t;

   trig_t q_trig[$];
   rsp_t  q_rsp[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rst_gen = 0;
   int trig_cnt [2] = '{0, 0};
   int rsp_cnt  [2] = '{0, 0};
   int last_trig[2] = '{0, 0};
   int last_rsp [2] = '{0, 0};
   bit prev_trig[2] = '{0, 0};
   bit have_rsp [2] = '{0, 0};

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic [N-1:0]    req_a = '0, lock_a = '0, grant_a, rsp_valid_a;
   logic [N*DW-1:0] req_data_a = '0;
   logic [DW-1:0]   rsp_data_a, spi_dout_a, spi_din_a, md_a, sd_a;
   logic            rsp_to_a, busy_a, trig_a, spi_vin_a, mv_a, sv_a;
   int              model_lat_a = 0;

   logic [N-1:0]    req_b = '0, lock_b = '0, grant_b, rsp_valid_b;
   logic [N*DW-1:0] req_data_b = '0;
   logic [DW-1:0]   rsp_data_b, spi_dout_b, spi_din_b, md_b, sd_b;
   logic            rsp_to_b, busy_b, trig_b, spi_vin_b, mv_b, sv_b;
   int              model_lat_b = 0;

   assign spi_vin_a = mv_a | sv_a;
   assign spi_din_a = mv_a ? md_a : sd_a;
   assign spi_vin_b = mv_b | sv_b;
   assign spi_din_b = mv_b ? md_b : sd_b;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(posedge rst) rst_gen++;

   spi_txn_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(4096)) u_dut_a (
      .clk_in(clk), .rst_in(rst), .req_in(req_a), .req_data_in(req_data_a),
      .req_lock_in(lock_a), .grant_out(grant_a), .rsp_data_out(rsp_data_a),
      .rsp_valid_out(rsp_valid_a), .rsp_timeout_out(rsp_to_a), .busy_out(busy_a),
      .spi_data_out(spi_dout_a), .spi_trigger_out(trig_a), .spi_data_in(spi_din_a),
      .spi_valid_in(spi_vin_a)
   );

   spi_txn_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(64)) u_dut_b (
      .clk_in(clk), .rst_in(rst), .req_in(req_b), .req_data_in(req_data_b),
      .req_lock_in(lock_b), .grant_out(grant_b), .rsp_data_out(rsp_data_b),
      .rsp_valid_out(rsp_valid_b), .rsp_timeout_out(rsp_to_b), .busy_out(busy_b),
      .spi_data_out(spi_dout_b), .spi_trigger_out(trig_b), .spi_data_in(spi_din_b),
      .spi_valid_in(spi_vin_b)
   );

   // spi_con models: answer model_lat cycles after the trigger unless reset intervenes.
   initial begin
      int gen;
      logic [DW-1:0] w;
      mv_a = 1'b0;
      md_a = '0;
      forever begin
         @(negedge clk);
         if (trig_a && !rst && model_lat_a > 0) begin
            gen = rst_gen;
            w   = spi_dout_a ^ 8'h99;
            repeat (model_lat_a) @(posedge clk);
            if (gen == rst_gen) begin
               #1 mv_a = 1'b1;
               md_a = w;
               @(posedge clk);
               #1 mv_a = 1'b0;
            end
         end
      end
   end

   initial begin
      int gen;
      logic [DW-1:0] w;
      mv_b = 1'b0;
      md_b = '0;
      forever begin
         @(negedge clk);
         if (trig_b && !rst && model_lat_b > 0) begin
            gen = rst_gen;
            w   = spi_dout_b ^ 8'h99;
            repeat (model_lat_b) @(posedge clk);
            if (gen == rst_gen) begin
               #1 mv_b = 1'b1;
               md_b = w;
               @(posedge clk);
               #1 mv_b = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_to(input string name);
      total++;
      bad++;
      $display("FAIL %s: wait budget expired (cycle %0d)", name, cyc);
   endtask

   task automatic mon(input int i, input logic trig, input logic [N-1:0] g,
                      input logic [DW-1:0] sdat, input logic [N-1:0] rv,
                      input logic [DW-1:0] rd, input logic rt);
      trig_t et;
      rsp_t  er;
      if (trig) begin
         trig_cnt[i]++;
         chk("trig_one_cycle", 32'(prev_trig[i]), 0);
         if (have_rsp[i]) chk("gap_before_trig", 32'(cyc - last_rsp[i] >= GAP), 1);
         if (q_trig.size() == 0) begin
            chk("unexpected_trig", 32'(trig), 0);
         end else begin
            et = q_trig.pop_front();
            chk("trig_inst", i, et.inst);
            chk("trig_grant", 32'(g), 32'(et.grant));
            chk("trig_data", 32'(sdat), 32'(et.data));
         end
         last_trig[i] = cyc;
      end
      prev_trig[i] = trig;
      if (rv != '0) begin
         rsp_cnt[i]++;
         last_rsp[i] = cyc;
         have_rsp[i] = 1'b1;
         chk("rsp_to_granted_owner", 32'(rv), 32'(g));
         if (q_rsp.size() == 0) begin
            chk("unexpected_rsp", 32'(rv), 0);
         end else begin
            er = q_rsp.pop_front();
            chk("rsp_inst", i, er.inst);
            chk("rsp_valid", 32'(rv), 32'(er.valid));
            chk("rsp_data", 32'(rd), 32'(er.data));
            chk("rsp_timeout", 32'(rt), 32'(er.to));
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, trig_a, grant_a, spi_dout_a, rsp_valid_a, rsp_data_a, rsp_to_a);
         mon(1, trig_b, grant_b, spi_dout_b, rsp_valid_b, rsp_data_b, rsp_to_b);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_txn(input int i, input logic [N-1:0] g, input logic [DW-1:0] sent,
                             input logic [DW-1:0] rcv, input logic to);
      q_trig.push_back('{i, g, sent});
      q_rsp.push_back('{i, g, rcv, to});
   endtask

   task automatic wait_trig(input int i, input int n, input string name);
      int k = 0;
      while (trig_cnt[i] < n && k < 3000) begin
         step();
         k++;
      end
      if (trig_cnt[i] < n) fail_to(name);
   endtask

   task automatic wait_rsp(input int i, input int n, input string name);
      int k = 0;
      while (rsp_cnt[i] < n && k < 3000) begin
         step();
         k++;
      end
      if (rsp_cnt[i] < n) fail_to(name);
   endtask

   task automatic wait_idle(input int i, input string name);
      int k = 0;
      while (((i == 0) ? busy_a : busy_b) && k < 200) begin
         step();
         k++;
      end
      if ((i == 0) ? busy_a : busy_b) fail_to(name);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      int tb, rb, k, hold_bad;
      sv_a = 1'b0; sd_a = '0;
      sv_b = 1'b0; sd_b = '0;

      // Async reset with no clock edge yet.
      #3 rst = 1'b1;
      #1;
      chk("rst_grant", 32'(grant_a), 0);
      chk("rst_trig", 32'(trig_a), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_rsp_valid", 32'(rsp_valid_a), 0);
      chk("rst_rsp_timeout", 32'(rsp_to_a), 0);
      chk("rst_spi_data", 32'(spi_dout_a), 0);
      chk("rst_rsp_data", 32'(rsp_data_a), 0);
      chk("rst_b_grant", 32'(grant_b), 0);
      repeat (3) step();
      rst = 1'b0;
      step();

      // Spurious spi valid while idle.
      sv_a = 1'b1;
      sd_a = 8'h5E;
      step();
      sv_a = 1'b0;
      chk("idle_spur_rsp", 32'(rsp_valid_a), 0);
      chk("idle_spur_busy", 32'(busy_a), 0);

      // Single request from requester 1.
      model_lat_a = 850;
      req_data_a  = 32'h0000_A500;
      expect_txn(0, 4'b0010, 8'hA5, 8'h3C, 1'b0);
      req_a = 4'b0010;
      step();
      chk("single_trig_latency", 32'(trig_a), 1);
      chk("single_grant", 32'(grant_a), 32'h2);
      chk("single_spi_data", 32'(spi_dout_a), 32'hA5);
      req_a      = '0;
      req_data_a = '0;
      k = 0;
      while (rsp_valid_a == '0 && k < 1000) begin
         step();
         k++;
      end
      if (rsp_valid_a == '0) fail_to("single_rsp");
      step();
      sv_a = 1'b1;
      sd_a = 8'h77;
      step();
      sv_a = 1'b0;
      chk("gap_spur_rsp", 32'(rsp_valid_a), 0);
      step();
      chk("single_grant_in_gap", 32'(grant_a), 32'h2);
      step();
      chk("single_grant_released", 32'(grant_a), 0);
      chk("single_busy_released", 32'(busy_a), 0);

      // Fairness: all four requesting from reset.
      model_lat_a = 5;
      req_data_a  = 32'h4332_2110;
      expect_txn(0, 4'b0001, 8'h10, 8'h89, 1'b0);
      expect_txn(0, 4'b0010, 8'h21, 8'hB8, 1'b0);
      expect_txn(0, 4'b0100, 8'h32, 8'hAB, 1'b0);
      expect_txn(0, 4'b1000, 8'h43, 8'hDA, 1'b0);
      expect_txn(0, 4'b0001, 8'h10, 8'h89, 1'b0);
      expect_txn(0, 4'b0010, 8'h21, 8'hB8, 1'b0);
      tb = trig_cnt[0];
      rb = rsp_cnt[0];
      rst = 1'b1;
      req_a = 4'b1111;
      step();
      step();
      rst = 1'b0;
      wait_trig(0, tb + 6, "fair_triggers");
      req_a = '0;
      wait_rsp(0, rb + 6, "fair_responses");
      wait_idle(0, "fair_idle");

      // Lock burst: requester 2 keeps the grant for three words while requester 0 waits.
      model_lat_a = 7;
      req_data_a  = 32'h0055_000A;
      lock_a      = 4'b0100;
      expect_txn(0, 4'b0100, 8'h55, 8'hCC, 1'b0);
      expect_txn(0, 4'b0100, 8'h66, 8'hFF, 1'b0);
      expect_txn(0, 4'b0100, 8'h77, 8'hEE, 1'b0);
      expect_txn(0, 4'b0001, 8'h0A, 8'h93, 1'b0);
      tb = trig_cnt[0];
      rb = rsp_cnt[0];
      req_a = 4'b0101;
      wait_trig(0, tb + 1, "lock_first_trig");
      req_data_a[23:16] = 8'h66;
      hold_bad = 0;
      k = 0;
      while (rsp_cnt[0] < rb + 3 && k < 3000) begin
         if (grant_a !== 4'b0100) hold_bad++;
         if (trig_cnt[0] >= tb + 2) req_data_a[23:16] = 8'h77;
         if (trig_cnt[0] >= tb + 3) lock_a = '0;
         step();
         k++;
      end
      if (rsp_cnt[0] < rb + 3) fail_to("lock_burst_rsps");
      chk("lock_grant_held", hold_bad, 0);
      wait_trig(0, tb + 4, "lock_handover_trig");
      req_a = '0;
      wait_rsp(0, rb + 4, "lock_handover_rsp");
      wait_idle(0, "lock_idle");

      // Async reset in WAIT, then the pointer must be back at 0.
      model_lat_a = 200;
      req_data_a  = 32'h0099_0000;
      req_a       = 4'b0100;
      step();
      chk("pre_rst_trig", 32'(trig_a), 1);
      req_a = '0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_trig", 32'(trig_a), 0);
      chk("mid_rst_grant", 32'(grant_a), 0);
      chk("mid_rst_busy", 32'(busy_a), 0);
      chk("mid_rst_spi_data", 32'(spi_dout_a), 0);
      step();
      rst = 1'b0;
      model_lat_a = 6;
      req_data_a  = 32'h7F00_003E;
      expect_txn(0, 4'b0001, 8'h3E, 8'hA7, 1'b0);
      expect_txn(0, 4'b1000, 8'h7F, 8'hE6, 1'b0);
      tb = trig_cnt[0];
      rb = rsp_cnt[0];
      req_a = 4'b1001;
      step();
      chk("post_rst_grant", 32'(grant_a), 32'h1);
      req_a = 4'b1000;
      wait_trig(0, tb + 2, "post_rst_trigs");
      req_a = '0;
      wait_rsp(0, rb + 2, "post_rst_rsps");
      wait_idle(0, "post_rst_idle");

      // Watchdog on instance b: timeout, normal service, valid coinciding with timeout.
      model_lat_b = 0;
      req_data_b  = 32'h815A_C300;
      expect_txn(1, 4'b0010, 8'hC3, 8'h00, 1'b1);
      expect_txn(1, 4'b0100, 8'h5A, 8'hC3, 1'b0);
      expect_txn(1, 4'b1000, 8'h81, 8'h18, 1'b0);
      tb = trig_cnt[1];
      rb = rsp_cnt[1];
      req_b = 4'b0110;
      wait_trig(1, tb + 1, "to_first_trig");
      req_b = 4'b0100;
      model_lat_b = 10;
      wait_rsp(1, rb + 1, "to_first_rsp");
      chk("timeout_latency", last_rsp[1] - last_trig[1], 64);
      wait_trig(1, tb + 2, "to_second_trig");
      req_b = 4'b1000;
      model_lat_b = 63;
      wait_rsp(1, rb + 2, "to_second_rsp");
      wait_trig(1, tb + 3, "to_third_trig");
      req_b = '0;
      wait_rsp(1, rb + 3, "to_third_rsp");
      chk("coincide_latency", last_rsp[1] - last_trig[1], 64);
      wait_idle(1, "to_idle");

      repeat (3) step();
      chk("trig_queue_drained", q_trig.size(), 0);
      chk("rsp_queue_drained", q_rsp.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
